instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch stage of the R-type CPU, sitting directly upstream of the instruction decoder. Holds the program counter and a small loadable instruction memory. Issues one 32-bit instruction per cycle, split into MIPS fields, through a valid/ready handshake so that decode can stall it. Stops on a programmable halt word.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width; depth is 2^ADDR_W words.
- `HALT_WORD`, default 32'hFC00_0000: end-of-program marker; it is never issued.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins fetching from PC 0; sampled only in IDLE.
- `load_en`  in  1  memory write strobe; honoured only in IDLE or HALT.
- `load_addr`  in  ADDR_W  word address for the write.
- `load_data`  in  32  word to write.
- `ready`  in  1  decode stage accepts the current instruction.
- `valid`  out  1  `instr` and its fields are valid.
- `instr`  out  32  fetched instruction.
- `pc_out`  out  32  byte address of `instr`.
- `op`  out  6  `instr[31:26]`.
- `rs`  out  5  `instr[25:21]`.
- `rt`  out  5  `instr[20:16]`.
- `rd`  out  5  `instr[15:11]`.
- `func`  out  6  `instr[5:0]`.
- `busy`  out  1  high while the state is FETCH.
- `fetch_cnt`  out  32  count of accepted instructions (see Configuration).

## Operation
- States:
  - IDLE (reset state).
  - FETCH.
  - HALT.
- Memory:
  - Array of 2^ADDR_W × 32 with combinational read.
  - Written on the clock edge when `load_en` is high and the state is IDLE or HALT.
  - Writes in FETCH are ignored.
  - `rst` does not clear memory contents.
- PC:
  - 32-bit byte address; the memory index is `pc[ADDR_W+1:2]`.
  - Increments by 4 per issued instruction.
  - Wraps from 4·(2^ADDR_W−1) to 0 without halting.
- IDLE → FETCH when `start`=1; `pc` is set to 0 at the same edge.
- In FETCH, the output slot is free when `valid`=0 or `ready`=1. When the slot is free:
  - If `mem[pc]` ≠ HALT_WORD: the output register takes `mem[pc]`, `pc_out` takes `pc`, `valid` goes to 1, and `pc` goes to `pc`+4.
  - If `mem[pc]` = HALT_WORD: `valid` goes to 0, the state goes to HALT, and `pc` holds the halt word's address.
- When the slot is not free (`valid`=1 and `ready`=0), `instr`, `pc_out`, the fields and `pc` all hold.
- HALT → FETCH on `start`, restarting at PC 0. `load_en` is allowed in HALT for reprogramming.
- The field outputs are pure slices of the registered `instr`.

## Timing
- Reset values:
  - State: IDLE.
  - `pc` and `pc_out`: 0.
  - `instr`: 0, so all fields are 0.
  - `valid`: 0.
  - `busy`: 0.
  - `fetch_cnt`: 0.
- Reset mid-operation takes effect immediately. Any in-flight instruction is dropped (`valid` goes to 0 asynchronously).
- Latency: `start` sampled at edge N, then FETCH from edge N, then `valid`=1 with `mem[0]` after edge N+1.
- Throughput: one instruction per cycle while `ready`=1.
- A transfer occurs at an edge where `valid`=1 and `ready`=1. `ready` may toggle freely; `valid` never drops without a transfer, except on reset or halt entry.
- Simultaneous `start` and `load_en` in IDLE: the write lands at edge N, and the first fetch at edge N+1 sees the new data.
- A halt word at address 0: FETCH lasts one cycle, then HALT, and `valid` never rises.
- `start` asserted while in FETCH is ignored.

## Configuration
- Macro: `IFU_FETCH_COUNT_EN`.
- Defined:
  - `fetch_cnt` increments by 1 on every transfer, wrapping at 2^32.
  - It is cleared by `rst` and by `start` accepted in IDLE or HALT.
- Undefined:
  - `fetch_cnt` is tied to 32'h0 and no counter logic is built.
  - All other behaviour is identical.

## Test plan
- **Basic run:** load `mem[0..2]` = 32'h0022_1820, 32'h0022_1822, HALT_WORD; pulse `start` with `ready`=1 → two transfers with `pc_out` 0 and 4; `op`=0, `func`=6'h20 then 6'h22, `rd`=3; then HALT, `busy`=0, `fetch_cnt`=2 (macro on) or 0 (macro off).
- **Stall:** `ready`=0 for 3 cycles while `valid`=1 at `pc_out`=4 → `instr` and `pc_out` hold for all 3 cycles; the next instruction appears the cycle after `ready` returns to 1; no instruction is skipped or duplicated.
- **Wrap:** ADDR_W=2, no halt word in memory, `ready`=1 → `pc_out` sequence 0, 4, 8, 12, 0, 4; the state stays FETCH.
- **Load gating:** `load_en` to address 1 during FETCH → memory unchanged; the same write in HALT, followed by `start`, fetches the new word at `pc_out`=4.
- **Reset mid-run:** assert `rst` asynchronously while `valid`=1 at `pc_out`=8 → `valid`, `pc_out` and `busy` drop to 0 immediately with no clock; memory is retained; `start` after release replays from PC 0.
- **Immediate halt:** `mem[0]` = HALT_WORD, then `start` → `valid` stays 0; the state is HALT two edges after `start`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: program counter, loadable instruction memory and a
// registered valid/ready output slot that issues one MIPS word per cycle.
// Fetching stops when the programmable HALT_WORD is read; that word is never issued.
// Optional feature macro: IFU_FETCH_COUNT_EN builds the accepted-instruction
// counter on fetch_cnt; without it fetch_cnt is constant zero.
module instr_fetch_unit #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              ready,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic              busy,
    output logic [31:0]       fetch_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [31:0]       mem [DEPTH];

    // pc_p0 addresses the word being looked up; the _p1 registers hold the issued slot
    logic [31:0]       pc_p0;
    logic [31:0]       pc_nxt;
    logic [31:0]       instr_p1;
    logic [31:0]       instr_nxt;
    logic [31:0]       pc_p1;
    logic [31:0]       pc_p1_nxt;
    logic              vld_p1;
    logic              vld_nxt;

    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] idx_inc;
    logic [31:0]       pc_inc;
    logic [31:0]       rd_word;
    logic              ctrl_open;
    logic              load_ok;
    logic              start_ok;
    logic              slot_free;

    // Memory index is the word part of the byte PC; incrementing only the index
    // makes the PC wrap from the last word back to 0 instead of leaving the array.
    assign rd_idx    = pc_p0[ADDR_W+1:2];
    assign rd_word   = mem[rd_idx];
    assign idx_inc   = rd_idx + ADDR_W'(1);
    assign pc_inc    = 32'(idx_inc) << 2;

    assign ctrl_open = (state == S_IDLE) || (state == S_HALT);
    assign load_ok   = load_en && ctrl_open;
    assign start_ok  = start && ctrl_open;
    assign slot_free = !vld_p1 || ready;

    // Instruction memory write port; contents survive reset so a program can be replayed
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    // State, PC and output-slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc_p0    <= 32'h0;
            pc_p1    <= 32'h0;
            instr_p1 <= 32'h0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_p0    <= pc_nxt;
            pc_p1    <= pc_p1_nxt;
            instr_p1 <= instr_nxt;
            vld_p1   <= vld_nxt;
        end
    end

    // Next-state and slot update: issue when the slot is free, halt on the marker word
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        pc_p1_nxt = pc_p1;
        instr_nxt = instr_p1;
        vld_nxt   = vld_p1;
        case (state)
            S_IDLE, S_HALT: begin
                if (start_ok) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = 32'h0;
                end
            end
            S_FETCH: begin
                if (slot_free) begin
                    if (rd_word != HALT_WORD) begin
                        instr_nxt = rd_word;
                        pc_p1_nxt = pc_p0;
                        vld_nxt   = 1'b1;
                        pc_nxt    = pc_inc;
                    end else begin
                        // pc stays on the halt word's address; the slot is emptied
                        vld_nxt   = 1'b0;
                        state_nxt = S_HALT;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] cnt_p1;
    logic        cnt_inc;

    assign cnt_inc = vld_p1 && ready;

    // Accepted-instruction counter, restarted with every new run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= 32'h0;
        end else if (start_ok) begin
            cnt_p1 <= 32'h0;
        end else if (cnt_inc) begin
            cnt_p1 <= cnt_p1 + 32'h1;
        end
    end

    assign fetch_cnt = cnt_p1;
`else
    assign fetch_cnt = 32'h0;
`endif

    assign valid  = vld_p1;
    assign instr  = instr_p1;
    assign pc_out = pc_p1;
    assign op     = instr_p1[31:26];
    assign rs     = instr_p1[25:21];
    assign rt     = instr_p1[20:16];
    assign rd     = instr_p1[15:11];
    assign func   = instr_p1[5:0];
    assign busy   = (state == S_FETCH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table-driven basic run, hand-written
// multi-cycle sequences, and randomized programs with random decode back-pressure
// checked against an issue-stream model derived from the bench's copy of memory.
module tb_instr_fetch_unit;

    localparam int          ADDR_W = 2;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] HALT   = 32'hFC00_0000;
`ifdef IFU_FETCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              ready;
    logic              valid;
    logic [31:0]       instr;
    logic [31:0]       pc_out;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        func;
    logic              busy;
    logic [31:0]       fetch_cnt;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .ready     (ready),
        .valid     (valid),
        .instr     (instr),
        .pc_out    (pc_out),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .func      (func),
        .busy      (busy),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic        exp_busy;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = d;
        step();
        load_en   = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic check_cnt(input string name, input int n);
        check(name, fetch_cnt, CNT_ON ? 32'(n) : 32'h0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    // Start a run and follow it to HALT; every accepted word must be the next
    // non-halt word of memory in address order, issued exactly once.
    task automatic run_and_check(input int pct, input string tag);
        logic [31:0] ew [$];
        logic [31:0] w;
        int          idx;
        bit          done;
        bit          xf;
        for (int k = 0; k < DEPTH; k++) begin
            if (model_mem[k] == HALT) break;
            ew.push_back(model_mem[k]);
        end
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'h1);
        idx  = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            ready = ($urandom_range(0, 99) < pct);
            xf    = valid && ready;
            step();
            if (xf) idx++;
            if (valid) begin
                check({tag, "_in_range"}, 32'(idx < ew.size()), 32'h1);
                if (idx < ew.size()) begin
                    w = ew[idx];
                    check({tag, "_pc"}, pc_out, 32'(idx * 4));
                    check({tag, "_instr"}, instr, w);
                    check({tag, "_func"}, 32'(func), 32'(w[5:0]));
                    check({tag, "_rd"}, 32'(rd), 32'(w[15:11]));
                end
            end
            if (!busy) done = 1'b1;
        end
        check({tag, "_halted_in_time"}, 32'(done), 32'h1);
        check({tag, "_issued"}, 32'(idx), 32'(ew.size()));
        check({tag, "_valid_in_halt"}, 32'(valid), 32'h0);
        check_cnt({tag, "_cnt"}, ew.size());
    endtask

    initial begin
        logic [31:0] wi;
        logic [31:0] w;
        int          p;
        int          guard;

        rst       = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        ready     = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0022_1820};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h0022_1822};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0022_1822};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0022_1822};

        // reset state
        #11;
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);
        check("rst_fields", {op, rs, rt, rd, func, 5'h0}, 32'h0);
        #1 rst = 1'b0;

        // basic run, table driven
        load_word(0, 32'h0022_1820);
        load_word(1, 32'h0022_1822);
        load_word(2, HALT);
        for (int i = 0; i < 5; i++) begin
            start = tbl[i].start;
            ready = tbl[i].ready;
            step();
            wi = tbl[i].exp_instr;
            check($sformatf("basic%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
            check($sformatf("basic%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("basic%0d_pc", i), pc_out, tbl[i].exp_pc);
            check($sformatf("basic%0d_instr", i), instr, wi);
            check($sformatf("basic%0d_op", i), 32'(op), 32'(wi[31:26]));
            check($sformatf("basic%0d_rs", i), 32'(rs), 32'(wi[25:21]));
            check($sformatf("basic%0d_rt", i), 32'(rt), 32'(wi[20:16]));
            check($sformatf("basic%0d_rd", i), 32'(rd), 32'(wi[15:11]));
            check($sformatf("basic%0d_func", i), 32'(func), 32'(wi[5:0]));
        end
        start = 1'b0;
        check_cnt("basic_cnt", 2);

        // stall with valid held at pc_out 4
        load_word(2, 32'h0143_4820);
        load_word(3, HALT);
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        check("stall_busy", 32'(busy), 32'h1);
        check("stall_first_latency", 32'(valid), 32'h0);
        step();
        check("stall_pc0", pc_out, 32'h0);
        check("stall_w0", instr, model_mem[0]);
        step();
        check("stall_pc4", pc_out, 32'h4);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold%0d_valid", i), 32'(valid), 32'h1);
            check($sformatf("stall_hold%0d_pc", i), pc_out, 32'h4);
            check($sformatf("stall_hold%0d_instr", i), instr, model_mem[1]);
        end
        ready = 1'b1;
        step();
        check("stall_next_pc", pc_out, 32'h8);
        check("stall_next_instr", instr, model_mem[2]);
        step();
        check("stall_halt_valid", 32'(valid), 32'h0);
        check("stall_halt_busy", 32'(busy), 32'h0);
        check_cnt("stall_cnt", 3);

        // load gating: a write during FETCH is dropped, a write in HALT lands
        start = 1'b1;
        ready = 1'b1;
        step();
        start     = 1'b0;
        load_en   = 1'b1;
        load_addr = 2'd1;
        load_data = 32'hDEAD_BEEF;
        step();
        load_en = 1'b0;
        step();
        check("gate_pc4", pc_out, 32'h4);
        check("gate_instr_unchanged", instr, 32'h0022_1822);
        step();
        step();
        check("gate_halted", 32'(busy), 32'h0);
        load_word(1, 32'h0085_3020);
        run_and_check(100, "reload");

        // asynchronous reset while pc_out 8 is valid; memory survives
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!(valid && pc_out == 32'h8) && guard < 8) begin
            step();
            guard++;
        end
        check("midrst_reached_pc8", 32'(valid && pc_out == 32'h8), 32'h1);
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_pc_out", pc_out, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_cnt", fetch_cnt, 32'h0);
        #2 rst = 1'b0;
        run_and_check(100, "replay");

        // simultaneous start and halt-word load at address 0 from IDLE
        pulse_reset();
        load_en   = 1'b1;
        load_addr = 2'd0;
        load_data = HALT;
        start     = 1'b1;
        ready     = 1'b1;
        step();
        model_mem[0] = HALT;
        load_en = 1'b0;
        start   = 1'b0;
        check("imm_busy_n", 32'(busy), 32'h1);
        check("imm_valid_n", 32'(valid), 32'h0);
        step();
        check("imm_busy_n1", 32'(busy), 32'h0);
        check("imm_valid_n1", 32'(valid), 32'h0);
        step();
        check("imm_valid_n2", 32'(valid), 32'h0);
        check("imm_pc_out", pc_out, 32'h0);

        // wrap with no halt word; a start during FETCH must not restart the run
        load_word(0, 32'h0000_0011);
        load_word(1, 32'h0000_0022);
        load_word(2, 32'h0000_0033);
        load_word(3, 32'h0000_0044);
        start = 1'b1;
        ready = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            start = (k == 2);
            step();
            check($sformatf("wrap%0d_pc", k), pc_out, 32'((4 * k) % (4 * DEPTH)));
            check($sformatf("wrap%0d_instr", k), instr, model_mem[k % DEPTH]);
            check($sformatf("wrap%0d_busy", k), 32'(busy), 32'h1);
        end
        start = 1'b0;
        pulse_reset();

        // randomized programs with random back-pressure
        for (int it = 0; it < 20; it++) begin
            p = $urandom_range(0, DEPTH - 1);
            for (int k = 0; k < DEPTH; k++) begin
                w = $urandom;
                if (w == HALT) w = 32'h0;
                if (k == p) w = HALT;
                load_word(k, w);
            end
            run_and_check($urandom_range(30, 100), $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
